// File: rtl/regfile_sb_pkg.sv
// Shared processor package: default datapath sizes and the register-index type
// used by decode, hazard and register-file logic.
package regfile_sb_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

   typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, squashed by flush, with a registered population count.
module regfile_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic              flush,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   pend_cnt
);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pend_next;
   logic [ADDR_W:0]     cnt_next;

   // Issue is applied after the writeback clear so a same-cycle issue to the
   // same register wins: it is the newer producer.
   always_comb begin
      pend_next = pending;
      if (flush) begin
         pend_next = '0;
      end else begin
         if (we)
            pend_next[waddr] = 1'b0;
         if (iss_valid)
            pend_next[iss_rd] = 1'b1;
      end
      if (ZERO_REG != 0)
         pend_next[0] = 1'b0;
   end

   always_comb begin
      cnt_next = '0;
      for (int i = 0; i < NUM_REGS; i++)
         cnt_next = cnt_next + {{ADDR_W{1'b0}}, pend_next[i]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         pending  <= pend_next;
         pend_cnt <= cnt_next;
      end
   end

   // A writeback landing this cycle is bypassed to the reader, so it no longer
   // counts as a hazard.
   always_comb begin
      busy1 = pending[rs1] && !(we && (waddr == rs1));
      busy2 = pending[rs2] && !(we && (waddr == rs2));
      if ((ZERO_REG != 0) && (rs1 == '0))
         busy1 = 1'b0;
      if ((ZERO_REG != 0) && (rs2 == '0))
         busy2 = 1'b0;
   end

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with writeback bypass and an attached
// pending-write scoreboard for hazard detection.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              busy1,
   output logic              busy2,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic              flush,
   output logic [ADDR_W:0]   pend_cnt
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            mem[i] <= '0;
      end else if (we && !((ZERO_REG != 0) && (waddr == '0))) begin
         mem[waddr] <= wdata;
      end
   end

   // Hardwired zero takes precedence over the writeback bypass.
   always_comb begin
      if ((ZERO_REG != 0) && (rs1 == '0))
         rdata1 = '0;
      else if (we && (waddr == rs1))
         rdata1 = wdata;
      else
         rdata1 = mem[rs1];

      if ((ZERO_REG != 0) && (rs2 == '0))
         rdata2 = '0;
      else if (we && (waddr == rs2))
         rdata2 = wdata;
      else
         rdata2 = mem[rs2];
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .waddr     (waddr),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .rs1       (rs1),
      .rs2       (rs2),
      .busy1     (busy1),
      .busy2     (busy2),
      .pend_cnt  (pend_cnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized scoreboard bench for regfile_sb against an array-based model of
// register contents and pending producers.
module tb_regfile_sb;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic [DW-1:0] rdata1;
   logic [DW-1:0] rdata2;
   logic          busy1;
   logic          busy2;
   logic          iss_valid;
   logic [AW-1:0] iss_rd;
   logic          flush;
   logic [AW:0]   pend_cnt;

   typedef struct {
      logic [DW-1:0] rdata1;
      logic [DW-1:0] rdata2;
      logic          busy1;
      logic          busy2;
      logic [AW:0]   pend_cnt;
      string         tag;
   } expect_t;

   expect_t exp_q[$];

   logic [DW-1:0] model_regs [NR];
   bit            model_pend [NR];

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .rs1       (rs1),
      .rs2       (rs2),
      .rdata1    (rdata1),
      .rdata2    (rdata2),
      .busy1     (busy1),
      .busy2     (busy2),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .pend_cnt  (pend_cnt)
   );

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] read_model(input logic w, input logic [AW-1:0] wa,
                                                input logic [DW-1:0] wd, input logic [AW-1:0] ra);
      if (ra == 0) return '0;
      if (w && wa == ra) return wd;
      return model_regs[ra];
   endfunction

   function automatic logic busy_model(input logic w, input logic [AW-1:0] wa, input logic [AW-1:0] ra);
      if (ra == 0) return 1'b0;
      return model_pend[ra] && !(w && wa == ra);
   endfunction

   // Drive one cycle of inputs, queue the response the outputs must show
   // during that cycle, then advance the model past the coming edge.
   task automatic apply_stimulus(input logic r, input logic w, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2, input logic iv,
                                 input logic [AW-1:0] ir, input logic fl, input string tag);
      expect_t e;
      int cnt;
      @(posedge clk);
      #1;
      rst_n = r; we = w; waddr = wa; wdata = wd; rs1 = a1; rs2 = a2;
      iss_valid = iv; iss_rd = ir; flush = fl;
      cnt = 0;
      foreach (model_pend[i]) cnt += int'(model_pend[i]);
      e.rdata1   = read_model(w, wa, wd, a1);
      e.rdata2   = read_model(w, wa, wd, a2);
      e.busy1    = busy_model(w, wa, a1);
      e.busy2    = busy_model(w, wa, a2);
      e.pend_cnt = (AW+1)'(cnt);
      e.tag      = tag;
      exp_q.push_back(e);
      if (!r) begin
         foreach (model_regs[i]) begin
            model_regs[i] = '0;
            model_pend[i] = 1'b0;
         end
      end else begin
         if (w && wa != 0) model_regs[wa] = wd;
         if (fl) begin
            foreach (model_pend[i]) model_pend[i] = 1'b0;
         end else begin
            if (w) model_pend[wa] = 1'b0;
            if (iv && ir != 0) model_pend[ir] = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      expect_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_output({e.tag, ".rdata1"}, rdata1, e.rdata1);
         check_output({e.tag, ".rdata2"}, rdata2, e.rdata2);
         check_output({e.tag, ".busy1"}, DW'(busy1), DW'(e.busy1));
         check_output({e.tag, ".busy2"}, DW'(busy2), DW'(e.busy2));
         check_output({e.tag, ".pend_cnt"}, DW'(pend_cnt), DW'(e.pend_cnt));
      end
   end

   initial begin
      int guard;
      foreach (model_regs[i]) begin
         model_regs[i] = '0;
         model_pend[i] = 1'b0;
      end
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; rs1 = '0; rs2 = '0;
      iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
      repeat (2) @(posedge clk);

      // Write and issue during reset must be discarded.
      apply_stimulus(0, 1, 5'd5, 32'h1111_2222, 5'd5, 5'd0, 1, 5'd5, 0, "rst_write");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0, 0, "post_rst");

      apply_stimulus(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 0, 5'd0, 0, "wr_r5");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0, 0, "rd_r5");
      apply_stimulus(1, 1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 0, 5'd0, 0, "bypass_r7");

      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd3, 0, "iss_r3");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd3, 5'd0, 0, 5'd0, 0, "busy_r3");
      apply_stimulus(1, 1, 5'd3, 32'hA5, 5'd3, 5'd3, 0, 5'd0, 0, "wb_r3");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd3, 5'd0, 0, 5'd0, 0, "after_wb_r3");

      apply_stimulus(1, 1, 5'd9, 32'h1, 5'd0, 5'd0, 1, 5'd9, 0, "iss_wb_r9");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd9, 5'd9, 0, 5'd0, 0, "still_r9");

      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd1, 0, "iss_r1");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd2, 0, "iss_r2");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd1, 5'd2, 1, 5'd4, 0, "iss_r4");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd4, 5'd9, 1, 5'd6, 1, "flush");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd1, 5'd6, 0, 5'd0, 0, "after_flush");
      apply_stimulus(1, 1, 5'd0, 32'hFFFF, 5'd0, 5'd0, 1, 5'd0, 0, "wr_r0");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd0, 5'd4, 0, 5'd0, 0, "rd_r0");

      apply_stimulus(1, 1, 5'd10, 32'h55, 5'd0, 5'd0, 1, 5'd10, 0, "wr_iss_r10");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd10, 5'd9, 0, 5'd0, 0, "pre_rst_r10");
      apply_stimulus(0, 0, 5'd0, 32'h0, 5'd10, 5'd9, 0, 5'd0, 0, "rst_r10");
      apply_stimulus(1, 0, 5'd0, 32'h0, 5'd10, 5'd9, 0, 5'd0, 0, "post_rst_r10");

      for (int n = 0; n < 600; n++) begin
         apply_stimulus(($urandom_range(63) != 0),
                        ($urandom_range(2) != 0),
                        AW'($urandom_range(NR-1)),
                        DW'($urandom),
                        AW'($urandom_range(NR-1)),
                        AW'($urandom_range(NR-1)),
                        ($urandom_range(1) != 0),
                        AW'($urandom_range(NR-1)),
                        ($urandom_range(15) == 0),
                        "rand");
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL drain: got %0d queued, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning register count (power of two, >=2); ADDR_W = log2(NUM_REGS).
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning when 1, register 0 reads as zero and ignores writes and issues.
REQ-004 SHALL use one clock and a synchronous, active-low reset, with these ports:
  clk        in   1       clock; all state updates on the rising edge
  rst_n      in   1       synchronous active-low reset
  we         in   1       writeback enable
  waddr      in   ADDR_W  writeback register index
  wdata      in   DATA_W  writeback data
  rs1        in   ADDR_W  read select 1
  rs2        in   ADDR_W  read select 2
  rdata1     out  DATA_W  read data 1
  rdata2     out  DATA_W  read data 2
  busy1      out  1       rs1 has a write pending
  busy2      out  1       rs2 has a write pending
  iss_valid  in   1       instruction issue; marks iss_rd pending
  iss_rd     in   ADDR_W  issue destination register
  flush      in   1       clear all pending bits (pipeline squash)
  pend_cnt   out  ADDR_W+1  number of pending registers

Function
REQ-005 SHALL hold NUM_REGS x DATA_W storage plus one pending bit per register.
REQ-006 SHALL, when we=1, write wdata to register waddr on the rising edge; otherwise storage is unchanged.
REQ-007 SHALL drive rdataN combinationally; latency is zero cycles.
REQ-008 SHALL forward writes to reads: if we=1 and waddr==rsN, rdataN = wdata in the same cycle.
REQ-009 SHALL, with ZERO_REG=1, return rdataN=0 and busyN=0 for rsN==0 regardless of we/waddr, drop writes to index 0, and ignore issues to index 0.
REQ-010 SHALL set pending[iss_rd] on the edge when iss_valid=1.
REQ-011 SHALL clear pending[waddr] on the edge when we=1.
REQ-012 SHALL leave pending[r] set when issue and writeback target the same r in one cycle, because the issue is the newer producer.
REQ-013 SHALL, when flush=1, clear every pending bit on the edge; an issue in the same cycle as flush SHALL also be discarded. Writes still update storage.
REQ-014 SHALL drive busyN = pending[rsN] AND NOT (we AND waddr==rsN); the in-flight writeback is consumed via bypass and reports not busy.
REQ-015 SHALL register pend_cnt equal to the population count of the pending bits after each edge; range 0..NUM_REGS (0..NUM_REGS-1 when ZERO_REG=1).
REQ-016 SHALL treat a writeback to a register that is not pending as a legal plain write, with no pending change.
REQ-017 SHALL give identical, independent results when rs1==rs2.

Reset
REQ-018 SHALL, on a rising edge with rst_n=0, clear all storage to 0, all pending bits to 0, and pend_cnt to 0; reset has priority over we, iss_valid and flush.
REQ-019 SHALL, during reset, drive rdataN from the bypass/storage path and busyN=0 once the first reset edge has occurred; no X on any output after that edge.
REQ-020 SHALL discard any write or issue presented in the reset cycle; the first post-reset write takes effect on the first edge with rst_n=1.

Structure
REQ-021 SHALL take DATA_W and NUM_REGS defaults and ADDR_W derivation from the shared processor package, which also holds a reg-index typedef reused by decode and hazard logic.
REQ-022 SHALL implement the pending bits, the set/clear/flush priority and pend_cnt in one sub-module, regfile_scoreboard; storage and bypass stay in the top.

Verification
REQ-023 Reset, then write r5=0xDEADBEEF -> next cycle rs1=5 gives rdata1=0xDEADBEEF; rs2=0 gives 0.
REQ-024 we=1, waddr=7, wdata=0x12345678, rs1=rs2=7 in the same cycle -> rdata1=rdata2=0x12345678 before the edge.
REQ-025 Issue r3; next cycle rs1=3 -> busy1=1, pend_cnt=1; then writeback r3=0xA5 with rs1=3 -> busy1=0, rdata1=0xA5; after the edge pend_cnt=0.
REQ-026 Issue r9 and writeback r9=0x1 in the same cycle -> after the edge pending[9]=1, busy for 9 = 1, storage r9=0x1.
REQ-027 Issue r1, r2, r4, then flush with iss_valid=1, iss_rd=6 -> pend_cnt=0, all busy=0; write r0=0xFFFF -> rs1=0 reads 0.
REQ-028 With r10=0x55 and pending[10]=1, assert rst_n=0 for one edge -> r10 reads 0, busy=0, pend_cnt=0.
